// File: rtl/usb_line_state_if.sv
// usb_line_state_if: pin and status bundle between the PHY-side line-state
// stage and its consumers (reset detector, suspend logic, bit recovery).
// The se1_err member exists only when USB_LS_SE1_ERR_EN is defined.
//
// Handshake note: this bundle carries level signals plus single-cycle
// strobes, with no valid/ready pair. dp_i/dn_i are asynchronous raw
// levels. line_state/se0/j/k/suspend are registered levels. line_change
// and resume are one-clock strobes that are valid on the cycle they are
// high and need no acknowledge.
interface usb_line_state_if;
  logic       dp_i;
  logic       dn_i;
  logic       dp_s;
  logic       dn_s;
  logic [1:0] line_state;
  logic       se0;
  logic       j;
  logic       k;
  logic       line_change;
  logic       suspend;
  logic       resume;
`ifdef USB_LS_SE1_ERR_EN
  logic       se1_err;
`endif

  // PHY / environment side: drives raw pins, observes decoded status
  modport master (
    output dp_i,
    output dn_i,
    input  dp_s,
    input  dn_s,
    input  line_state,
    input  se0,
    input  j,
    input  k,
    input  line_change,
    input  suspend,
`ifdef USB_LS_SE1_ERR_EN
    input  se1_err,
`endif
    input  resume
  );

  // Line-state block side
  modport slave (
    input  dp_i,
    input  dn_i,
    output dp_s,
    output dn_s,
    output line_state,
    output se0,
    output j,
    output k,
    output line_change,
    output suspend,
`ifdef USB_LS_SE1_ERR_EN
    output se1_err,
`endif
    output resume
  );
endinterface

// File: rtl/usb_line_state.sv
// usb_line_state: USB front-end line-state stage.
// Synchronises raw D+/D-, decodes SE0/J/K/SE1, glitch-filters the decoded
// state, and tracks bus idle (suspend) and resume signalling.
// Optional feature macro: USB_LS_SE1_ERR_EN adds a sticky se1_err flag.
// Speed selection comes from types::USB_FULL_SPEED. It can be overridden
// per instance through the FULL_SPEED parameter.

package types;
  // 1 = full speed (J = D+ high), 0 = low speed (J = D- high)
  parameter bit USB_FULL_SPEED = 1'b1;
endpackage

module usb_line_state #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILT_LEN       = 3,
  parameter int unsigned SUSPEND_CYCLES = 144000,
  parameter bit          FULL_SPEED     = types::USB_FULL_SPEED
) (
  input logic             clk,
  input logic             reset_ni,
  usb_line_state_if.slave bus
);

  // Line-state encoding. The registered state doubles as the observable
  // state of this block (bus.line_state).
  typedef enum logic [1:0] {
    LS_SE0 = 2'd0,
    LS_J   = 2'd1,
    LS_K   = 2'd2,
    LS_SE1 = 2'd3
  } ls_e;

  // Parameters below their minimum are clamped so the datapath stays well formed.
  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned FILT_N = (FILT_LEN < 1) ? 1 : FILT_LEN;
  localparam int unsigned SUSP_N = (SUSPEND_CYCLES < 1) ? 1 : SUSPEND_CYCLES;

  localparam int unsigned STAB_W = $clog2(FILT_N + 1);
  localparam int unsigned IDLE_W = $clog2(SUSP_N + 1);

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(FILT_N);
  localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(SUSP_N);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

  // Pin levels of an idle (J) bus. The synchroniser resets to these so that
  // coming out of reset never looks like SE0 to the reset detector.
  localparam logic IDLE_DP = FULL_SPEED ? 1'b1 : 1'b0;
  localparam logic IDLE_DN = FULL_SPEED ? 1'b0 : 1'b1;

  // Synchroniser chains; the last stage is the synchronised pin
  logic [SYNC_N-1:0] r_dp_sync;
  logic [SYNC_N-1:0] r_dn_sync;

  // Glitch filter: previous decoded state and its run length
  ls_e               r_prev_dec;
  logic [STAB_W-1:0] r_stab;

  // Registered outputs
  ls_e               r_line_state;
  logic              r_se0;
  logic              r_j;
  logic              r_k;
  logic              r_line_change;
  logic              r_suspend;
  logic              r_resume;
  logic [IDLE_W-1:0] r_idle;

  // Combinational next-state values
  logic              w_dp_s;
  logic              w_dn_s;
  ls_e               w_dec;
  logic [STAB_W-1:0] w_stab_next;
  logic              w_update;
  ls_e               w_ls_next;
  logic [IDLE_W-1:0] w_idle_next;
  logic              w_suspend_next;
  logic              w_resume_next;

  // Map pin pair to line state; J/K polarity depends on bus speed
  function automatic ls_e decode(input logic dp, input logic dn);
    ls_e res;
    case ({dp, dn})
      2'b00:   res = LS_SE0;
      2'b11:   res = LS_SE1;
      2'b10:   res = FULL_SPEED ? LS_J : LS_K;
      default: res = FULL_SPEED ? LS_K : LS_J;
    endcase
    return res;
  endfunction

  assign w_dp_s = r_dp_sync[SYNC_N-1];
  assign w_dn_s = r_dn_sync[SYNC_N-1];

  // Shift raw pins through the synchroniser chains
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_dp_sync <= {SYNC_N{IDLE_DP}};
      r_dn_sync <= {SYNC_N{IDLE_DN}};
    end else begin
      r_dp_sync <= {r_dp_sync[SYNC_N-2:0], bus.dp_i};
      r_dn_sync <= {r_dn_sync[SYNC_N-2:0], bus.dn_i};
    end
  end

  // Filter: count how long the decoded state has held, including this cycle.
  // Accept the state once it has held FILT_N cycles and differs from the
  // current line state.
  always_comb begin
    w_dec       = decode(w_dp_s, w_dn_s);
    w_stab_next = STAB_ONE;
    if (w_dec == r_prev_dec) begin
      w_stab_next = (r_stab == STAB_MAX) ? r_stab : (r_stab + STAB_ONE);
    end
    w_update  = (w_stab_next == STAB_MAX) && (w_dec != r_line_state);
    w_ls_next = w_update ? w_dec : r_line_state;
  end

  // Idle tracking: a line-state update always wins over counter saturation.
  // Any update leaves J or enters J from a non-idle state, so it clears the
  // counter and suspend. A K accepted while suspended is a resume.
  always_comb begin
    w_idle_next    = '0;
    w_suspend_next = 1'b0;
    w_resume_next  = 1'b0;
    if (w_update) begin
      w_resume_next = (w_dec == LS_K) && r_suspend;
    end else if (r_line_state == LS_J) begin
      w_idle_next    = (r_idle == IDLE_MAX) ? r_idle : (r_idle + IDLE_ONE);
      w_suspend_next = r_suspend || (r_idle == IDLE_MAX);
    end
  end

  // Filter state registers
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_prev_dec <= LS_J;
      r_stab     <= '0;
    end else begin
      r_prev_dec <= w_dec;
      r_stab     <= w_stab_next;
    end
  end

  // Line state and its one-hot decodes, registered together
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_line_state  <= LS_J;
      r_se0         <= 1'b0;
      r_j           <= 1'b1;
      r_k           <= 1'b0;
      r_line_change <= 1'b0;
    end else begin
      r_line_state  <= w_ls_next;
      r_se0         <= (w_ls_next == LS_SE0);
      r_j           <= (w_ls_next == LS_J);
      r_k           <= (w_ls_next == LS_K);
      r_line_change <= w_update;
    end
  end

  // Idle counter, suspend level and resume strobe
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_idle    <= '0;
      r_suspend <= 1'b0;
      r_resume  <= 1'b0;
    end else begin
      r_idle    <= w_idle_next;
      r_suspend <= w_suspend_next;
      r_resume  <= w_resume_next;
    end
  end

`ifdef USB_LS_SE1_ERR_EN
  logic r_se1_err;

  // Sticky SE1 flag: set when SE1 is accepted, cleared only by reset
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_se1_err <= 1'b0;
    end else if (w_update && (w_dec == LS_SE1)) begin
      r_se1_err <= 1'b1;
    end
  end

  assign bus.se1_err = r_se1_err;
`endif

  assign bus.dp_s        = w_dp_s;
  assign bus.dn_s        = w_dn_s;
  assign bus.line_state  = r_line_state;
  assign bus.se0         = r_se0;
  assign bus.j           = r_j;
  assign bus.k           = r_k;
  assign bus.line_change = r_line_change;
  assign bus.suspend     = r_suspend;
  assign bus.resume      = r_resume;

endmodule

// File: tb/tb_usb_line_state.sv
// tb_usb_line_state: directed bench for usb_line_state (full speed).
// Stimulus pushes the expected update (edge, state, resume) into exp_q.
// A monitor pops one entry on every line_change and compares it.
module tb_usb_line_state;
  localparam int SYNC = 2;
  localparam int FILT = 3;
  localparam int SUSP = 100;
  localparam int LAT  = SYNC + FILT - 1;
  localparam int W    = 19;

  localparam logic [1:0] SE0 = 2'd0;
  localparam logic [1:0] LJ  = 2'd1;
  localparam logic [1:0] LK  = 2'd2;
  localparam logic [1:0] SE1 = 2'd3;

  logic clk = 1'b0;
  logic reset_ni;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_upd = 0;
  int   rel_edge = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [22:0]  mon_act;
  logic [22:0]  mon_exp;

  usb_line_state_if bus_if();

  usb_line_state #(
    .SYNC_STAGES   (SYNC),
    .FILT_LEN      (FILT),
    .SUSPEND_CYCLES(SUSP)
  ) dut (
    .clk     (clk),
    .reset_ni(reset_ni),
    .bus     (bus_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Queue the update the DUT must show LAT edges after the next edge
  task automatic expect_upd(input logic [1:0] ls, input logic res);
    last_upd = edge_cnt + 1 + LAT;
    exp_q.push_back({16'(last_upd), ls, res});
  endtask

  // Drive a pin pair for 'hold' clocks, optionally queueing its acceptance
  task automatic send(input logic dp, input logic dn, input int hold,
                      input bit push, input logic [1:0] ls, input logic res);
    bus_if.dp_i = dp;
    bus_if.dn_i = dn;
    if (push) expect_upd(ls, res);
    tick_n(hold);
  endtask

  // Advance to a given edge count with a bounded wait
  task automatic wait_edge(input int target);
    for (int i = 0; i < 1000 && edge_cnt < target; i++) tick();
    if (edge_cnt != target) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_edge: at edge %0d wanted %0d", edge_cnt, target);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_ni === 1'b1 && (bus_if.line_change || bus_if.resume)) begin
      n_checks++;
      if (!bus_if.line_change) begin
        n_errors++;
        $display("FAIL resume_alone: resume=1 with line_change=0 at edge %0d", edge_cnt);
      end else if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_change: line_state=%0d at edge %0d, none expected",
                 bus_if.line_state, edge_cnt);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_exp = {mon_e[18:3], mon_e[2:1], mon_e[2:1] == SE0, mon_e[2:1] == LJ,
                   mon_e[2:1] == LK, mon_e[0], 1'b0};
        mon_act = {16'(edge_cnt), bus_if.line_state, bus_if.se0, bus_if.j, bus_if.k,
                   bus_if.resume, bus_if.suspend};
        if (mon_act !== mon_exp) begin
          n_errors++;
          $display("FAIL update {edge,ls,se0,j,k,resume,suspend}: got %0d,%0d,%b%b%b,%b,%b expected %0d,%0d,%b%b%b,%b,%b",
                   mon_act[22:7], mon_act[6:5], mon_act[4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                   mon_exp[22:7], mon_exp[6:5], mon_exp[4], mon_exp[3], mon_exp[2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset_ni     = 1'b0;
    bus_if.dp_i  = 1'b0;
    bus_if.dn_i  = 1'b0;

    // Reset with SE0 on the pins: idle J outputs, never se0
    #12;
    check("rst_line_state", 32'(bus_if.line_state), 32'(LJ));
    check("rst_se0", 32'(bus_if.se0), 0);
    check("rst_j", 32'(bus_if.j), 1);
    check("rst_k", 32'(bus_if.k), 0);
    check("rst_suspend", 32'(bus_if.suspend), 0);
    check("rst_line_change", 32'(bus_if.line_change), 0);
    check("rst_dp_s", 32'(bus_if.dp_s), 1);
    check("rst_dn_s", 32'(bus_if.dn_s), 0);
`ifdef USB_LS_SE1_ERR_EN
    check("rst_se1_err", 32'(bus_if.se1_err), 0);
`endif
    tick();
    reset_ni = 1'b1;
    expect_upd(SE0, 1'b0);
    tick_n(7);
    check("se0_after_release", 32'(bus_if.se0), 1);

    // Back to idle J
    send(1'b1, 1'b0, 8, 1'b1, LJ, 1'b0);

    // Glitch: SE0 for 2 clocks is discarded
    send(1'b0, 1'b0, 2, 1'b0, SE0, 1'b0);
    send(1'b1, 1'b0, 6, 1'b0, LJ, 1'b0);
    check("glitch_se0", 32'(bus_if.se0), 0);

    // SE0 for 3 clocks is accepted for exactly 3 cycles
    send(1'b0, 1'b0, 3, 1'b1, SE0, 1'b0);
    send(1'b1, 1'b0, 8, 1'b1, LJ, 1'b0);

    // Latency: J->K, synchronised pins move at edge 1, k at edge 4
    bus_if.dp_i = 1'b0;
    bus_if.dn_i = 1'b1;
    expect_upd(LK, 1'b0);
    tick();
    check("dp_s_edge0", 32'(bus_if.dp_s), 1);
    tick();
    check("dp_s_edge1", 32'(bus_if.dp_s), 0);
    check("dn_s_edge1", 32'(bus_if.dn_s), 1);
    tick_n(4);
    check("k_level", 32'(bus_if.k), 1);
    send(1'b1, 1'b0, 6, 1'b1, LJ, 1'b0);

    // SE1: decoded as state 3, all one-hot flags low
    send(1'b1, 1'b1, 3, 1'b1, SE1, 1'b0);
    send(1'b1, 1'b0, 6, 1'b1, LJ, 1'b0);
`ifdef USB_LS_SE1_ERR_EN
    check("se1_err_sticky", 32'(bus_if.se1_err), 1);
`endif

    // Update lands on the edge where suspend would assert: update wins
    wait_edge(last_upd + SUSP + 1 - 1 - LAT);
    send(1'b0, 1'b1, 6, 1'b1, LK, 1'b0);
    check("no_suspend_on_tie", 32'(bus_if.suspend), 0);
    send(1'b1, 1'b0, 6, 1'b1, LJ, 1'b0);

    // Suspend asserts on the edge after the counter reaches SUSP
    wait_edge(last_upd + SUSP);
    check("suspend_edge100", 32'(bus_if.suspend), 0);
    tick();
    check("suspend_edge101", 32'(bus_if.suspend), 1);
    tick_n(20);
    check("suspend_held", 32'(bus_if.suspend), 1);

    // K from suspend: resume pulse, suspend drops on the same edge
    send(1'b0, 1'b1, 5, 1'b1, LK, 1'b1);
    check("suspend_after_k", 32'(bus_if.suspend), 0);
    send(1'b1, 1'b0, 6, 1'b1, LJ, 1'b0);

    // SE0 from suspend: suspend drops, no resume
    wait_edge(last_upd + SUSP + 1);
    check("suspend_again", 32'(bus_if.suspend), 1);
    send(1'b0, 1'b0, 5, 1'b1, SE0, 1'b0);
    check("suspend_after_se0", 32'(bus_if.suspend), 0);
    check("se0_after_suspend", 32'(bus_if.se0), 1);
    send(1'b1, 1'b0, 6, 1'b1, LJ, 1'b0);

    // Async reset mid-suspend: outputs clear with no clock edge
    wait_edge(last_upd + SUSP + 10);
    check("suspend_pre_reset", 32'(bus_if.suspend), 1);
    @(posedge clk);
    #2;
    reset_ni = 1'b0;
    #1;
    check("async_rst_suspend", 32'(bus_if.suspend), 0);
    check("async_rst_line_state", 32'(bus_if.line_state), 32'(LJ));
`ifdef USB_LS_SE1_ERR_EN
    check("async_rst_se1_err", 32'(bus_if.se1_err), 0);
`endif
    tick();
    reset_ni = 1'b1;
    rel_edge = edge_cnt;

    // Idle counter restarts from zero after reset
    wait_edge(rel_edge + SUSP);
    check("recount_edge100", 32'(bus_if.suspend), 0);
    tick();
    check("recount_edge101", 32'(bus_if.suspend), 1);

    // Drain the scoreboard
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected updates never seen", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
